// File: rtl/bin_to_dec_seq_pkg.sv
// Shared definitions for the binary-to-decimal line sequencer.
//   state_t  : sequencer states (IDLE, DRIVE, GAP)
//   MAX_CODE : highest code that owns an output line
//   CNT_W    : width of the hold/gap down-counter
//   cnt_t    : counter type
package dec_pkg;

  localparam int MAX_CODE = 7;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bin_to_dec_seq_if.sv
// Handshake and decoded-line bundle for bin_to_dec_seq.
//   i_b       : 4-bit binary code (0..7 legal, 8..15 illegal)
//   i_valid   : i_b is presented for transfer
//   o_ready   : sequencer accepts i_b this cycle
//   o_d1..o_d7: registered one-hot decoded lines
//   o_busy    : sequencer is not idle
//   o_err     : one-cycle pulse after an illegal code is accepted
// master drives the code, slave is the sequencer.
interface bin_to_dec_seq_if;

  logic [3:0] i_b;
  logic       i_valid;
  logic       o_ready;
  logic       o_d1;
  logic       o_d2;
  logic       o_d3;
  logic       o_d4;
  logic       o_d5;
  logic       o_d6;
  logic       o_d7;
  logic       o_busy;
  logic       o_err;

  modport master (
    output i_b, i_valid,
    input  o_ready, o_d1, o_d2, o_d3, o_d4, o_d5, o_d6, o_d7, o_busy, o_err
  );

  modport slave (
    input  i_b, i_valid,
    output o_ready, o_d1, o_d2, o_d3, o_d4, o_d5, o_d6, o_d7, o_busy, o_err
  );

endinterface

// File: rtl/bin_to_onehot.sv
// Combinational decoder: 4-bit code to MAX_CODE-bit one-hot.
//   code   : binary input
//   onehot : bit N-1 set for code N in 1..MAX_CODE; all zero for 0 and 8..15
module bin_to_onehot
  import dec_pkg::*;
(
  input  logic [3:0]          code,
  output logic [MAX_CODE-1:0] onehot
);

  always_comb begin
    for (int n = 1; n <= MAX_CODE; n++) begin
      onehot[n-1] = (code == 4'(n));
    end
  end

endmodule

// File: rtl/bin_to_dec_seq.sv
// Binary-to-decimal line sequencer. An accepted code 1..7 drives its line
// for HOLD_CYCLES cycles, then the block idles GAP_CYCLES cycles before it
// accepts another code. Code 0 is a no-op; codes 8..15 raise o_err once.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : bin_to_dec_seq_if slave (handshake, decoded lines, status)
// Parameters: HOLD_CYCLES (1..255), GAP_CYCLES (0..255).
module bin_to_dec_seq
  import dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  bin_to_dec_seq_if.slave  bus
);

  // Counter reload values; the counter runs N-1 down to 0 so a phase lasts N cycles.
  localparam cnt_t       HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam cnt_t       GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [3:0] MAX_CODE_B = 4'(MAX_CODE);

  state_t              state_q, state_n;
  cnt_t                cnt_q,   cnt_n;
  logic [3:0]          code_q,  code_n;
  logic [MAX_CODE-1:0] d_q;
  logic [MAX_CODE-1:0] dec;
  logic                err_q,   err_n;
  logic                ready;
  logic                xfer;

  assign ready = (state_q == IDLE) && !i_rst;
  assign xfer  = bus.i_valid && ready;

  // Decode the code that will be held next cycle, so the line register
  // turns on in the same edge that enters DRIVE.
  bin_to_onehot u_dec (
    .code   (code_n),
    .onehot (dec)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_n = state_q;
    cnt_n   = cnt_q;
    code_n  = code_q;
    err_n   = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (bus.i_b > MAX_CODE_B) begin
            err_n = 1'b1;
          end else if (bus.i_b != 4'd0) begin
            code_n  = bus.i_b;
            cnt_n   = HOLD_LOAD;
            state_n = DRIVE;
          end
        end
      end

      DRIVE: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            cnt_n   = GAP_LOAD;
            state_n = GAP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      code_q  <= code_n;
      d_q     <= (state_n == DRIVE) ? dec : '0;
      err_q   <= err_n;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_err   = err_q;
  assign bus.o_d1    = d_q[0];
  assign bus.o_d2    = d_q[1];
  assign bus.o_d3    = d_q[2];
  assign bus.o_d4    = d_q[3];
  assign bus.o_d5    = d_q[4];
  assign bus.o_d6    = d_q[5];
  assign bus.o_d7    = d_q[6];

endmodule

// File: doc/bin_to_dec_seq.md
BIN_TO_DEC_SEQ -- requirements
Module: bin_to_dec_seq

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles a decoded line is driven high (legal range 1..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, giving the number of idle cycles after a drive before the next code is accepted (legal range 0..255).
REQ-003 The block SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port i_b  input  4  binary code; 0..7 legal, 8..15 illegal.
REQ-006 The block SHALL have port i_valid  input  1  i_b is presented for transfer.
REQ-007 The block SHALL have port o_ready  output  1  block accepts i_b this cycle.
REQ-008 The block SHALL have ports o_d1..o_d7  output  1 each  decoded one-hot lines; o_dN corresponds to code N.
REQ-009 The block SHALL have port o_busy  output  1  high whenever the state is not IDLE.
REQ-010 The block SHALL have port o_err  output  1  one-cycle pulse flagging an accepted illegal code.

Function
REQ-011 A transfer SHALL occur on a rising edge where i_valid and o_ready are both high; i_valid while o_ready is low SHALL be ignored and SHALL NOT be captured.
REQ-012 o_ready SHALL equal (state == IDLE) and (not i_rst).
REQ-013 The FSM SHALL have states IDLE, DRIVE and GAP.
REQ-014 IDLE, transfer of code 1..7: the code SHALL be registered, the FSM SHALL go to DRIVE, and the hold counter SHALL load HOLD_CYCLES-1.
REQ-015 IDLE, transfer of code 0: the FSM SHALL remain in IDLE, no line SHALL assert, and o_ready SHALL stay high.
REQ-016 IDLE, transfer of code 8..15: the FSM SHALL remain in IDLE, no line SHALL assert, and o_err SHALL be high for exactly the next cycle.
REQ-017 In DRIVE, exactly the line selected by the registered code SHALL be high and all other lines low; all lines SHALL be registered outputs.
REQ-018 Latency: for a transfer at edge N, the selected line SHALL be high for exactly the HOLD_CYCLES cycles following edges N..N+HOLD_CYCLES-1.
REQ-019 DRIVE SHALL decrement the counter each cycle; at counter 0 the FSM SHALL go to GAP (counter loads GAP_CYCLES-1) if GAP_CYCLES>0, else to IDLE.
REQ-020 In GAP all lines SHALL be low and o_ready low; at counter 0 the FSM SHALL go to IDLE.
REQ-021 Back-to-back: with GAP_CYCLES=0 and i_valid held high, a new transfer SHALL occur in the first IDLE cycle, leaving one all-low cycle between drives.
REQ-022 In IDLE all o_dN SHALL be low.
REQ-023 The counter SHALL be 8 bits wide, unsigned, and SHALL never wrap below 0.
REQ-024 o_err SHALL NOT assert in any state other than the cycle after an illegal-code transfer.

Reset
REQ-025 While i_rst is high at a rising edge, the next state SHALL be IDLE, the counter and registered code 0, all o_dN 0, o_err 0, and o_busy 0.
REQ-026 Reset asserted mid-DRIVE or mid-GAP SHALL abort the operation with no residual line pulse after the reset edge.
REQ-027 o_ready SHALL be 0 while i_rst is high and 1 in the first cycle after i_rst deasserts.

Structure
REQ-028 A shared package dec_pkg SHALL hold the state enum (IDLE, DRIVE, GAP), the constant MAX_CODE=7, and the counter width constant CNT_W=8.
REQ-029 A combinational sub-module bin_to_onehot (4-bit code to 7-bit one-hot, zero for 0 and for 8..15) SHALL perform the decode, and its output SHALL be registered in bin_to_dec_seq.
REQ-030 The block SHALL be one always_ff for state, counter, code and outputs, plus one always_comb for next-state logic.

Verification (HOLD_CYCLES=4, GAP_CYCLES=1 unless stated)
REQ-031 Code 3, one-cycle valid at edge N -> o_d3 high for 4 cycles after edge N, others low; o_ready low for 5 cycles; o_busy high for the same 5 cycles.
REQ-032 Codes 0 and then 12 -> no line asserts; o_ready stays high; o_err pulses exactly once, one cycle after the 12 transfer.
REQ-033 i_valid held high with code 7, then code 1 presented during DRIVE -> only code 7 is driven; code 1 is accepted in the next IDLE cycle and o_d1 is driven for 4 cycles.
REQ-034 Reset asserted on the 2nd DRIVE cycle of code 5 -> o_d5 low after the reset edge; o_ready 0 during reset and 1 after.
REQ-035 GAP_CYCLES=0, HOLD_CYCLES=1, stream of codes 1..7 -> each line high for 1 cycle with one low cycle between pulses, in order.
REQ-036 All codes 0..15 sweep -> per-code one-hot match for codes 1..7, no output for 0, o_err for 8..15.
